pair_accumulate: RTL and testbench
==================================

PAIR_ACCUMULATE -- requirements
Module: pair_accumulate

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of every value port and internal register.
REQ-002 SHALL have port _clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port _reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port _start  input  1  high for one cycle to capture n and begin a run.
REQ-005 SHALL have port n  input  WIDTH signed  run length forwarded to upstream; sampled only when _start is high.
REQ-006 SHALL have port _up_n  output  WIDTH signed  argument to the upstream tuple generator.
REQ-007 SHALL have port _up_start  output  1  start pulse to upstream.
REQ-008 SHALL have port _up_ready  output  1  ready to upstream.
REQ-009 SHALL have ports _up_valid, _up_done  input  1 each  valid and done-pulse from upstream.
REQ-010 SHALL have ports _up_out0, _up_out1  input  WIDTH signed each  upstream tuple.
REQ-011 SHALL have port _ready  input  1  downstream ready.
REQ-012 SHALL have port _valid  output  1  _out0/_out1 valid.
REQ-013 SHALL have port _done  output  1  one-cycle pulse at end of run.
REQ-014 SHALL have port _out0  output  WIDTH signed  running sum of (out0+out1).
REQ-015 SHALL have port _out1  output  WIDTH unsigned  count of tuples consumed.

Function
REQ-016 SHALL implement states IDLE, CALL, FETCH, EMIT, DONE.
REQ-017 _start SHALL take precedence over all other state activity: capture n, clear acc/cnt/done_seen, go CALL, from any state.
REQ-018 CALL (one cycle) SHALL drive _up_n=captured n, _up_start=1, _up_ready=0, then go FETCH; _up_start SHALL be high for exactly that one cycle per run.
REQ-019 FETCH SHALL hold _up_ready=1; on _up_valid&&_up_ready: acc+=_up_out0+_up_out1, cnt+=1, _up_ready<=0, go EMIT.
REQ-020 A _up_done pulse in any state except IDLE SHALL set sticky done_seen; it is never missed while EMIT is stalled.
REQ-021 FETCH with done_seen set and no accepted tuple SHALL go DONE.
REQ-022 _up_valid and _up_done in the same cycle: tuple is accepted first, DONE follows after its EMIT.
REQ-023 EMIT SHALL load _out0=acc, _out1=cnt (post-update), assert _valid, return to FETCH.
REQ-024 _valid SHALL stay high with stable data until a cycle with _ready high; it clears in that cycle.
REQ-025 States SHALL advance only when _ready || !_valid (upstream done capture excepted).
REQ-026 DONE SHALL pulse _done for one cycle and go IDLE; _done is 0 otherwise.
REQ-027 Sum SHALL be signed WIDTH-bit, wrapping modulo 2^WIDTH; cnt unsigned wrapping.
REQ-028 IDLE SHALL ignore upstream inputs and hold _up_ready=0, _up_start=0.
REQ-029 Latency: _start at cycle 0 -> _up_start high cycle 1; first _valid no earlier than 2 cycles after upstream first _valid.

Reset
REQ-030 _reset_n low SHALL immediately force IDLE and zero _valid, _done, _up_start, _up_ready, _out0, _out1, _up_n, acc, cnt, done_seen, regardless of _clock.
REQ-031 Reset deasserted SHALL require a fresh _start; reset mid-run SHALL discard all progress.

Verification
REQ-032 Upstream counting generator, n=4, _ready=1 -> outputs (0,1),(2,2),(6,3),(12,4), then one _done pulse, exactly one _up_start.
REQ-033 n=0 (upstream pulses done, no valid) -> _valid never high, _done pulses once, return IDLE.
REQ-034 n=3, _ready low 5 cycles on first output, upstream done pulses during stall -> _out0=0,_out1=1 held stable; then (2,2),(6,3), then _done.
REQ-035 WIDTH=8, tuples (100,100),(100,100) -> _out0 = -56 then -112 (wrap), _out1 = 1 then 2.
REQ-036 _reset_n low mid-run after 2 outputs -> all outputs 0 asynchronously; new _start n=2 -> (0,1),(2,2), _done.
REQ-037 _start reasserted mid-run with n=2 -> acc/cnt cleared, new _up_start, outputs (0,1),(2,2), single _done.

Source files
------------

// File: rtl/pair_accumulate.sv
// Pair accumulator: starts an upstream tuple generator, sums out0+out1 of every
// tuple it consumes and emits the running sum and tuple count downstream.
module pair_accumulate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] n,
  output logic signed [WIDTH-1:0] _up_n,
  output logic                    _up_start,
  output logic                    _up_ready,
  input  logic                    _up_valid,
  input  logic                    _up_done,
  input  logic signed [WIDTH-1:0] _up_out0,
  input  logic signed [WIDTH-1:0] _up_out1,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _out0,
  output logic        [WIDTH-1:0] _out1
);

  localparam int unsigned SW = 3;
  localparam logic [SW-1:0] IDLE  = 3'd0;
  localparam logic [SW-1:0] CALL  = 3'd1;
  localparam logic [SW-1:0] FETCH = 3'd2;
  localparam logic [SW-1:0] EMIT  = 3'd3;
  localparam logic [SW-1:0] DONE  = 3'd4;

  logic [SW-1:0]           state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic                    done_seen_q, done_seen_d;
  logic signed [WIDTH-1:0] up_n_d;
  logic                    up_start_d, up_ready_d;
  logic                    valid_d, done_d;
  logic signed [WIDTH-1:0] out0_d;
  logic [WIDTH-1:0]        out1_d;
  logic                    adv_c;

  // Next-state and next-output logic; _start overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    done_seen_d = done_seen_q;
    up_n_d      = _up_n;
    up_start_d  = _up_start;
    up_ready_d  = _up_ready;
    valid_d     = _valid;
    done_d      = 1'b0;
    out0_d      = _out0;
    out1_d      = _out1;

    adv_c = _ready || !_valid;

    // Downstream took the current word.
    if (_valid && _ready) valid_d = 1'b0;

    // Upstream done is sticky so it is not lost while an output is stalled.
    if (state_q != IDLE && _up_done) done_seen_d = 1'b1;

    case (state_q)
      IDLE: begin
        up_start_d = 1'b0;
        up_ready_d = 1'b0;
      end
      // Output queue is always empty here (cleared on _start), so the start
      // pulse is kept to exactly one cycle.
      CALL: begin
        up_start_d = 1'b0;
        up_ready_d = 1'b1;
        state_d    = FETCH;
      end
      // A tuple already handshaken with upstream is always taken; emission of
      // the new sum waits in EMIT until the output register is free.
      FETCH: begin
        if (_up_valid && _up_ready) begin
          acc_d      = acc_q + _up_out0 + _up_out1;
          cnt_d      = cnt_q + WIDTH'(1);
          up_ready_d = 1'b0;
          state_d    = EMIT;
        end else if (done_seen_q && adv_c) begin
          up_ready_d = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      EMIT: begin
        if (adv_c) begin
          out0_d     = acc_q;
          out1_d     = cnt_q;
          valid_d    = 1'b1;
          up_ready_d = 1'b1;
          state_d    = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        up_start_d = 1'b0;
        up_ready_d = 1'b0;
      end
    endcase

    if (_start) begin
      up_n_d      = n;
      acc_d       = '0;
      cnt_d       = '0;
      done_seen_d = 1'b0;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      up_ready_d  = 1'b0;
      up_start_d  = 1'b1;
      state_d     = CALL;
    end
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      done_seen_q <= 1'b0;
      _up_n       <= '0;
      _up_start   <= 1'b0;
      _up_ready   <= 1'b0;
      _valid      <= 1'b0;
      _done       <= 1'b0;
      _out0       <= '0;
      _out1       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      done_seen_q <= done_seen_d;
      _up_n       <= up_n_d;
      _up_start   <= up_start_d;
      _up_ready   <= up_ready_d;
      _valid      <= valid_d;
      _done       <= done_d;
      _out0       <= out0_d;
      _out1       <= out1_d;
    end
  end

endmodule

// File: tb/tb_pair_accumulate.sv
// Directed bench for pair_accumulate with a counting upstream generator model.
module tb_pair_accumulate;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, ready;
  logic signed [W-1:0] n, up_n, up_out0, up_out1, out0;
  logic [W-1:0] out1;
  logic up_start, up_ready, up_valid, up_done, valid, done;

  logic start8, ready8;
  logic signed [W8-1:0] n8, up_n8, up_out0_8, up_out1_8, out0_8;
  logic [W8-1:0] out1_8;
  logic up_start8, up_ready8, up_valid8, up_done8, valid8, done8;

  pair_accumulate #(.WIDTH(W)) dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start), .n(n),
    ._up_n(up_n), ._up_start(up_start), ._up_ready(up_ready),
    ._up_valid(up_valid), ._up_done(up_done),
    ._up_out0(up_out0), ._up_out1(up_out1),
    ._ready(ready), ._valid(valid), ._done(done), ._out0(out0), ._out1(out1)
  );

  pair_accumulate #(.WIDTH(W8)) dut8 (
    ._clock(clk), ._reset_n(rst_n), ._start(start8), .n(n8),
    ._up_n(up_n8), ._up_start(up_start8), ._up_ready(up_ready8),
    ._up_valid(up_valid8), ._up_done(up_done8),
    ._up_out0(up_out0_8), ._up_out1(up_out1_8),
    ._ready(ready8), ._valid(valid8), ._done(done8), ._out0(out0_8), ._out1(out1_8)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Output monitor (sampled on the active edge, before DUT updates land).
  logic [63:0] q0[$], q1[$], q80[$], q81[$];
  int done_cnt, ups_cnt, valid_cnt, done8_cnt;
  bit hs, saw_start, hs8, saw_start8;

  always @(posedge clk) begin
    if (valid && ready) begin q0.push_back(64'(out0)); q1.push_back(64'(out1)); end
    if (valid8 && ready8) begin q80.push_back(64'(out0_8)); q81.push_back(64'(out1_8)); end
    if (done)      done_cnt++;
    if (done8)     done8_cnt++;
    if (up_start)  ups_cnt++;
    if (valid)     valid_cnt++;
    if (up_valid && up_ready)   hs = 1'b1;
    if (up_start)               saw_start = 1'b1;
    if (up_valid8 && up_ready8) hs8 = 1'b1;
    if (up_start8)              saw_start8 = 1'b1;
  end

  // Upstream counting generator: tuple i is (i, i), then a one-cycle done.
  int  gen_n, idx, gen8_n, idx8;
  bit  active, active8, force_done, suppress_done;

  always @(negedge clk) begin
    up_done  = 1'b0;
    up_done8 = 1'b0;
    if (!rst_n) begin
      active = 1'b0; active8 = 1'b0;
      up_valid = 1'b0; up_out0 = '0; up_out1 = '0;
      up_valid8 = 1'b0; up_out0_8 = '0; up_out1_8 = '0;
      hs = 1'b0; saw_start = 1'b0; hs8 = 1'b0; saw_start8 = 1'b0;
    end else begin
      if (saw_start) begin active = 1'b1; idx = 0; gen_n = int'(up_n); end
      else if (hs) idx++;
      saw_start = 1'b0; hs = 1'b0;
      if (active && idx < gen_n) begin
        up_valid = 1'b1; up_out0 = W'(idx); up_out1 = W'(idx);
      end else begin
        up_valid = 1'b0;
        if (active) begin up_done = !suppress_done; active = 1'b0; end
      end
      if (force_done) up_done = 1'b1;

      if (saw_start8) begin active8 = 1'b1; idx8 = 0; gen8_n = int'(up_n8); end
      else if (hs8) idx8++;
      saw_start8 = 1'b0; hs8 = 1'b0;
      if (active8 && idx8 < gen8_n) begin
        up_valid8 = 1'b1; up_out0_8 = 8'sd100; up_out1_8 = 8'sd100;
      end else begin
        up_valid8 = 1'b0;
        if (active8) begin up_done8 = 1'b1; active8 = 1'b0; end
      end
    end
  end

  task automatic clear_mon();
    q0.delete(); q1.delete(); q80.delete(); q81.delete();
    done_cnt = 0; ups_cnt = 0; valid_cnt = 0; done8_cnt = 0;
  endtask

  task automatic run_start(input int nv);
    n = W'(nv); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0 && done8_cnt == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_seq(input string tag, input int cnt, input int e0[4], input int e1[4]);
    check({tag, "_count"}, 64'(q0.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < q0.size(); i++) begin
      check($sformatf("%s_out0_%0d", tag, i), q0[i], 64'(e0[i]));
      check($sformatf("%s_out1_%0d", tag, i), q1[i], 64'(e1[i]));
    end
  endtask

  int e0[4], e1[4];

  initial begin
    rst_n = 1'b0; start = 1'b0; n = '0; ready = 1'b1;
    start8 = 1'b0; n8 = '0; ready8 = 1'b1;
    force_done = 1'b0; suppress_done = 1'b0;
    clear_mon();
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_up_start", 64'(up_start), 64'd0);
    check("rst_up_ready", 64'(up_ready), 64'd0);
    check("rst_out0", 64'(out0), 64'd0);
    check("rst_out1", 64'(out1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run of four tuples.
    clear_mon();
    run_start(4);
    check("n4_up_start_cycle1", 64'(up_start), 64'd1);
    check("n4_up_n", 64'(up_n), 64'd4);
    check("n4_up_ready_in_call", 64'(up_ready), 64'd0);
    wait_done(100);
    e0 = '{0, 2, 6, 12}; e1 = '{1, 2, 3, 4};
    check_seq("n4", 4, e0, e1);
    check("n4_done_pulses", 64'(done_cnt), 64'd1);
    check("n4_up_start_pulses", 64'(ups_cnt), 64'd1);
    check("n4_idle_up_ready", 64'(up_ready), 64'd0);

    // Empty run.
    clear_mon();
    run_start(0);
    wait_done(50);
    check("n0_valid_cycles", 64'(valid_cnt), 64'd0);
    check("n0_done_pulses", 64'(done_cnt), 64'd1);
    check("n0_idle_up_ready", 64'(up_ready), 64'd0);

    // Downstream stall on first output with upstream done arriving mid-stall.
    clear_mon();
    suppress_done = 1'b1;
    run_start(3);
    for (int i = 0; i < 50 && !valid; i++) @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      force_done = (i == 1);
      check($sformatf("stall_valid_%0d", i), 64'(valid), 64'd1);
      check($sformatf("stall_out0_%0d", i), 64'(out0), 64'd0);
      check($sformatf("stall_out1_%0d", i), 64'(out1), 64'd1);
      @(negedge clk);
    end
    force_done = 1'b0;
    ready = 1'b1;
    wait_done(100);
    suppress_done = 1'b0;
    e0 = '{0, 2, 6, 0}; e1 = '{1, 2, 3, 0};
    check_seq("stall", 3, e0, e1);
    check("stall_done_pulses", 64'(done_cnt), 64'd1);

    // Signed wrap at WIDTH=8.
    clear_mon();
    n8 = 8'sd2; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(50);
    check("w8_count", 64'(q80.size()), 64'd2);
    if (q80.size() == 2) begin
      check("w8_out0_0", q80[0], -64'sd56);
      check("w8_out1_0", q81[0], 64'd1);
      check("w8_out0_1", q80[1], -64'sd112);
      check("w8_out1_1", q81[1], 64'd2);
    end
    check("w8_done_pulses", 64'(done8_cnt), 64'd1);

    // Asynchronous reset mid-run, then a fresh short run.
    clear_mon();
    run_start(4);
    for (int i = 0; i < 100 && q0.size() < 2; i++) @(negedge clk);
    check("rstmid_progress", 64'(q0.size()), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(valid), 64'd0);
    check("rstmid_up_ready", 64'(up_ready), 64'd0);
    check("rstmid_up_start", 64'(up_start), 64'd0);
    check("rstmid_out0", 64'(out0), 64'd0);
    check("rstmid_out1", 64'(out1), 64'd0);
    check("rstmid_up_n", 64'(up_n), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_restart", 64'(up_ready), 64'd0);
    clear_mon();
    run_start(2);
    wait_done(60);
    e0 = '{0, 2, 0, 0}; e1 = '{1, 2, 0, 0};
    check_seq("after_rst", 2, e0, e1);
    check("after_rst_done", 64'(done_cnt), 64'd1);

    // Restart mid-run discards progress.
    clear_mon();
    run_start(4);
    for (int i = 0; i < 100 && q0.size() < 1; i++) @(negedge clk);
    check("restart_progress", 64'(q0.size()), 64'd1);
    run_start(2);
    clear_mon();
    wait_done(60);
    e0 = '{0, 2, 0, 0}; e1 = '{1, 2, 0, 0};
    check_seq("restart", 2, e0, e1);
    check("restart_done", 64'(done_cnt), 64'd1);
    check("restart_up_start", 64'(ups_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
